// File: rtl/plugin_mmio_queue_if.sv
// Data-memory bus seen by the accelerator front end: one access per cycle,
// byte enables select write vs read, read data returned combinationally.
interface plugin_mmio_queue_if;
    logic        enable_i;
    logic [3:0]  we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        irq_o;

    modport master (output enable_i, we_i, addr_i, data_i, input data_o, irq_o);
    modport slave  (input enable_i, we_i, addr_i, data_i, output data_o, irq_o);
endinterface

// File: rtl/plugin_mmio_queue.sv
// Memory-mapped ALU accelerator: operand staging registers, a command FIFO,
// a multi-cycle execute engine and a result FIFO behind a 6-word window.
//
// state  | meaning
// S_IDLE | engine free; takes the cmd FIFO head when one is present
// S_EXEC | counting down LATENCY cycles, result computed on the last one
// S_WB   | holding the result until the result FIFO has room
module plugin_mmio_queue #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 4,
    parameter int          LATENCY   = 2
) (
    input logic                clk,
    input logic                reset_n,
    plugin_mmio_queue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [LW-1:0] LAT_INIT = LW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    logic [31:0]       offset;
    logic [2:0]        widx;
    logic              hit, wr, rd;

    logic [DATA_W-1:0] opa, opb;
    logic              irq_en, ovf_flag, udf_flag, irq_q;

    logic [DATA_W-1:0] ca_mem [DEPTH];
    logic [DATA_W-1:0] cb_mem [DEPTH];
    logic [1:0]        cop_mem [DEPTH];
    logic [AW-1:0]     c_wptr, c_rptr;
    logic [CW-1:0]     c_cnt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_cnt;

    state_t            state;
    logic [LW-1:0]     cnt;
    logic [DATA_W-1:0] e_a, e_b, e_res;
    logic [1:0]        e_op;

    logic cmd_hit, res_hit, clr_hit;
    logic cmd_full, res_full, cmd_push, cmd_pop, res_push, res_pop;
    logic [31:0] status, rdata;

    // Low two address bits are ignored: the window is decoded per word.
    assign offset = bus.addr_i - BASE_ADDR;
    assign hit    = bus.enable_i && (offset < 32'd24);
    assign widx   = offset[4:2];
    assign wr     = hit && (bus.we_i != 4'd0);
    assign rd     = hit && (bus.we_i == 4'd0);

    assign cmd_hit  = wr && (widx == 3'd2);
    assign res_hit  = rd && (widx == 3'd3);
    assign clr_hit  = wr && (widx == 3'd5) && bus.data_i[1];
    assign cmd_full = (c_cnt == FULL_CNT);
    assign res_full = (r_cnt == FULL_CNT);
    // Full is judged on the pre-edge count, so a same-cycle engine pop never rescues a push.
    assign cmd_push = cmd_hit && !cmd_full;
    assign cmd_pop  = (state == S_IDLE) && (c_cnt != '0);
    assign res_push = (state == S_WB) && !res_full;
    assign res_pop  = res_hit && (r_cnt != '0);

    function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [1:0]        op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Software-visible registers, sticky error flags and the interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opa      <= '0;
            opb      <= '0;
            irq_en   <= 1'b0;
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && widx == 3'd0) opa    <= bus.data_i[DATA_W-1:0];
            if (wr && widx == 3'd1) opb    <= bus.data_i[DATA_W-1:0];
            if (wr && widx == 3'd5) irq_en <= bus.data_i[0];
            // A new error in the same cycle as a clear wins.
            ovf_flag <= (cmd_hit && cmd_full) || (ovf_flag && !clr_hit);
            udf_flag <= (res_hit && (r_cnt == '0)) || (udf_flag && !clr_hit);
            irq_q    <= irq_en && ((r_cnt != '0) || ovf_flag || udf_flag);
        end
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_wptr <= '0;
            c_rptr <= '0;
            c_cnt  <= '0;
        end else begin
            if (cmd_push) c_wptr <= c_wptr + AW'(1);
            if (cmd_pop)  c_rptr <= c_rptr + AW'(1);
            case ({cmd_push, cmd_pop})
                2'b10:   c_cnt <= c_cnt + CW'(1);
                2'b01:   c_cnt <= c_cnt - CW'(1);
                default: c_cnt <= c_cnt;
            endcase
        end
    end

    // Command storage; operands are captured from the staging regs at push time.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            ca_mem[c_wptr]  <= opa;
            cb_mem[c_wptr]  <= opb;
            cop_mem[c_wptr] <= bus.data_i[1:0];
        end
    end

    // Execute engine.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            e_a   <= '0;
            e_b   <= '0;
            e_op  <= '0;
            e_res <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_pop) begin
                        e_a   <= ca_mem[c_rptr];
                        e_b   <= cb_mem[c_rptr];
                        e_op  <= cop_mem[c_rptr];
                        cnt   <= LAT_INIT;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        e_res <= alu(e_a, e_b, e_op);
                        state <= S_WB;
                    end else begin
                        cnt <= cnt - LW'(1);
                    end
                end
                S_WB: begin
                    if (!res_full) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (res_push) r_wptr <= r_wptr + AW'(1);
            if (res_pop)  r_rptr <= r_rptr + AW'(1);
            case ({res_push, res_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Result storage.
    always_ff @(posedge clk) begin
        if (res_push) r_mem[r_wptr] <= e_res;
    end

    // STATUS word; counts are log2(DEPTH)+1 bits wide so a full FIFO is representable.
    always_comb begin
        status          = '0;
        status[0]       = (state != S_IDLE) || (c_cnt != '0);
        status[1]       = cmd_full;
        status[2]       = (r_cnt != '0);
        status[3]       = ovf_flag;
        status[4]       = udf_flag;
        status[5 +: CW] = c_cnt;
        status[16 +: CW] = r_cnt;
    end

    // Read mux; anything other than a read hitting the window returns zero.
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (widx)
                3'd0:    rdata = 32'(opa);
                3'd1:    rdata = 32'(opb);
                3'd3:    if (r_cnt != '0) rdata = 32'(r_mem[r_rptr]);
                3'd4:    rdata = status;
                3'd5:    rdata = {31'd0, irq_en};
                default: rdata = '0;
            endcase
        end
    end

    assign bus.data_o = rdata;
    assign bus.irq_o  = irq_q;
endmodule
